// File: rtl/gpio_in_debounce.sv
// rtl/gpio_in_debounce.sv - pin synchroniser, per-channel debouncer, edge pulses, sticky pending bits and irq
//
// Ports:
//   i_clk       clock (single domain)
//   i_reset     asynchronous active-low reset
//   i_pin_in    raw asynchronous pin levels, CH bits
//   o_db_out    debounced level, drives the GPIO block's gpio_in
//   o_rise      one-cycle pulse when o_db_out goes 0->1
//   o_fall      one-cycle pulse when o_db_out goes 1->0
//   o_pend      sticky per-channel edge-pending bits
//   i_pend_clr  write-1-to-clear strobe for o_pend
//   o_irq       OR of the pending bits

module gpio_in_debounce #(
    parameter int CH         = 8,
    parameter int DEB_CYCLES = 50000,
    parameter int CNT_W      = 16
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [CH-1:0] i_pin_in,
    output logic [CH-1:0] o_db_out,
    output logic [CH-1:0] o_rise,
    output logic [CH-1:0] o_fall,
    output logic [CH-1:0] o_pend,
    input  logic [CH-1:0] i_pend_clr,
    output logic          o_irq
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic [CH-1:0]    r_s1;
    logic [CH-1:0]    r_s2;
    logic [CH-1:0]    r_db;
    logic [CH-1:0]    r_rise;
    logic [CH-1:0]    r_fall;
    logic [CH-1:0]    r_pend;
    logic [CNT_W-1:0] r_cnt [CH];

    logic [CH-1:0]    w_diff;
    logic [CH-1:0]    w_accept;

    // A channel accepts its new level once it has disagreed with the
    // debounced level for DEB_CYCLES consecutive edges.
    always_comb begin
        w_diff   = r_s2 ^ r_db;
        w_accept = '0;
        for (int i = 0; i < CH; i++) begin
            w_accept[i] = w_diff[i] && (r_cnt[i] == CNT_MAX);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_db   <= '0;
            r_rise <= '0;
            r_fall <= '0;
            r_pend <= '0;
            for (int i = 0; i < CH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1   <= i_pin_in;
            r_s2   <= r_s1;
            r_db   <= r_db ^ w_accept;
            r_rise <= w_accept & r_s2;
            r_fall <= w_accept & ~r_s2;
            // A new edge outranks a simultaneous clear so no event is lost.
            r_pend <= (r_pend & ~i_pend_clr) | w_accept;
            for (int i = 0; i < CH; i++) begin
                // Agreement restarts the count (glitch rejected); acceptance
                // also restarts it, so it never exceeds CNT_MAX.
                if (!w_diff[i] || w_accept[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign o_db_out = r_db;
    assign o_rise   = r_rise;
    assign o_fall   = r_fall;
    assign o_pend   = r_pend;
    assign o_irq    = |r_pend;

endmodule

// File: tb/tb_gpio_in_debounce.sv
// tb/tb_gpio_in_debounce.sv - scoreboard bench for gpio_in_debounce (CH=4, DEB_CYCLES=4)

module tb_gpio_in_debounce;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] pin;
    logic [3:0] clr;
    logic [3:0] o_db_out, o_rise, o_fall, o_pend;
    logic       o_irq;

    typedef struct {
        int         cyc;
        logic [3:0] r;
        logic [3:0] f;
    } ev_t;

    ev_t        q[$];
    int         ncyc  = 0;
    int         total = 0;
    int         bad   = 0;
    logic [3:0] m_db   = '0;
    logic [3:0] m_rise = '0;
    logic [3:0] m_fall = '0;
    logic [3:0] m_pend = '0;

    gpio_in_debounce #(.CH(4), .DEB_CYCLES(4), .CNT_W(16)) dut (
        .i_clk      (clk),
        .i_reset    (rst_n),
        .i_pin_in   (pin),
        .o_db_out   (o_db_out),
        .o_rise     (o_rise),
        .o_fall     (o_fall),
        .o_pend     (o_pend),
        .i_pend_clr (clr),
        .o_irq      (o_irq)
    );

    always #5 clk = ~clk;

    // A pin change driven after edge n is first captured at edge n+1 and
    // becomes the debounced level at edge n+6 (DEB_CYCLES + 2).
    task automatic push(input logic [3:0] r, input logic [3:0] f);
        ev_t e;
        e.cyc = ncyc + 6;
        e.r   = r;
        e.f   = f;
        q.push_back(e);
    endtask

    // One clock edge; the model consumes the scoreboard entry due at it.
    task automatic cyc();
        logic [3:0] c;
        logic       rs;
        ev_t        e;
        c  = clr;
        rs = rst_n;
        @(posedge clk);
        #1;
        ncyc++;
        m_rise = '0;
        m_fall = '0;
        if (!rs) begin
            m_db   = '0;
            m_pend = '0;
            q.delete();
        end else begin
            while (q.size() != 0 && q[0].cyc <= ncyc) begin
                e = q.pop_front();
                if (e.cyc == ncyc) begin
                    m_rise |= e.r;
                    m_fall |= e.f;
                end
            end
            m_db   = (m_db | m_rise) & ~m_fall;
            m_pend = (m_pend & ~c) | m_rise | m_fall;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pin   = 4'hF;
        clr   = 4'h0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            total++;
            if ({o_db_out, o_rise, o_fall, o_pend, o_irq} !== {m_db, m_rise, m_fall, m_pend, |m_pend}) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d got db=%h r=%h f=%h p=%h irq=%b want db=%h r=%h f=%h p=%h irq=%b",
                         ncyc, o_db_out, o_rise, o_fall, o_pend, o_irq, m_db, m_rise, m_fall, m_pend, |m_pend);
            end
        end
        rst_n = 1'b1;
        push(4'hF, 4'h0);
        for (int k = 0; k < 8; k++) begin
            cyc();
            total++;
            if ({o_db_out, o_rise, o_fall, o_pend, o_irq} !== {m_db, m_rise, m_fall, m_pend, |m_pend}) begin
                bad++;
                $display("FAIL reset_release cyc=%0d got db=%h r=%h f=%h p=%h irq=%b want db=%h r=%h f=%h p=%h irq=%b",
                         ncyc, o_db_out, o_rise, o_fall, o_pend, o_irq, m_db, m_rise, m_fall, m_pend, |m_pend);
            end
        end
        clr = 4'hF;
        cyc();
        clr = 4'h0;
    endtask

    task automatic test_glitch();
        pin = 4'h0;
        push(4'h0, 4'hF);
        for (int k = 0; k < 8; k++) cyc();
        clr = 4'hF;
        cyc();
        clr = 4'h0;
        // 3 high cycles: rejected; then 4 high cycles: accepted, then falls
        for (int rep = 3; rep <= 4; rep++) begin
            pin[0] = 1'b1;
            if (rep == 4) push(4'h1, 4'h0);
            for (int k = 0; k < rep; k++) begin
                cyc();
                total++;
                if ({o_db_out, o_rise, o_fall, o_pend, o_irq} !== {m_db, m_rise, m_fall, m_pend, |m_pend}) begin
                    bad++;
                    $display("FAIL glitch_high%0d cyc=%0d got db=%h r=%h f=%h p=%h irq=%b want db=%h r=%h f=%h p=%h irq=%b",
                             rep, ncyc, o_db_out, o_rise, o_fall, o_pend, o_irq, m_db, m_rise, m_fall, m_pend, |m_pend);
                end
            end
            pin[0] = 1'b0;
            if (rep == 4) push(4'h0, 4'h1);
            for (int k = 0; k < 8; k++) begin
                cyc();
                total++;
                if ({o_db_out, o_rise, o_fall, o_pend, o_irq} !== {m_db, m_rise, m_fall, m_pend, |m_pend}) begin
                    bad++;
                    $display("FAIL glitch_low%0d cyc=%0d got db=%h r=%h f=%h p=%h irq=%b want db=%h r=%h f=%h p=%h irq=%b",
                             rep, ncyc, o_db_out, o_rise, o_fall, o_pend, o_irq, m_db, m_rise, m_fall, m_pend, |m_pend);
                end
            end
        end
        clr = 4'hF;
        cyc();
        clr = 4'h0;
    endtask

    task automatic test_bounce();
        for (int k = 0; k < 20; k++) begin
            pin[1] = ((k / 2) % 2 == 0);
            cyc();
            total++;
            if ({o_db_out, o_rise, o_fall, o_pend, o_irq} !== {m_db, m_rise, m_fall, m_pend, |m_pend}) begin
                bad++;
                $display("FAIL bounce cyc=%0d got db=%h r=%h f=%h p=%h irq=%b want db=%h r=%h f=%h p=%h irq=%b",
                         ncyc, o_db_out, o_rise, o_fall, o_pend, o_irq, m_db, m_rise, m_fall, m_pend, |m_pend);
            end
        end
        pin[1] = 1'b1;
        push(4'h2, 4'h0);
        for (int k = 0; k < 8; k++) begin
            cyc();
            total++;
            if ({o_db_out, o_rise, o_fall, o_pend, o_irq} !== {m_db, m_rise, m_fall, m_pend, |m_pend}) begin
                bad++;
                $display("FAIL bounce_settle cyc=%0d got db=%h r=%h f=%h p=%h irq=%b want db=%h r=%h f=%h p=%h irq=%b",
                         ncyc, o_db_out, o_rise, o_fall, o_pend, o_irq, m_db, m_rise, m_fall, m_pend, |m_pend);
            end
        end
        clr = 4'hF;
        cyc();
        clr = 4'h0;
    endtask

    task automatic test_clear_race();
        pin[2] = 1'b1;
        push(4'h4, 4'h0);
        for (int k = 0; k < 8; k++) cyc();
        pin[2] = 1'b0;
        push(4'h0, 4'h4);
        // clear lands on the fall edge (set wins), then again one edge later
        for (int k = 1; k <= 10; k++) begin
            clr = (k == 6 || k == 7) ? 4'h4 : 4'h0;
            cyc();
            total++;
            if ({o_db_out, o_rise, o_fall, o_pend, o_irq} !== {m_db, m_rise, m_fall, m_pend, |m_pend}) begin
                bad++;
                $display("FAIL clear_race k=%0d got db=%h r=%h f=%h p=%h irq=%b want db=%h r=%h f=%h p=%h irq=%b",
                         k, o_db_out, o_rise, o_fall, o_pend, o_irq, m_db, m_rise, m_fall, m_pend, |m_pend);
            end
        end
        clr = 4'h0;
    endtask

    task automatic test_reset_mid();
        pin = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            cyc();
            total++;
            if ({o_db_out, o_rise, o_fall, o_pend, o_irq} !== {m_db, m_rise, m_fall, m_pend, |m_pend}) begin
                bad++;
                $display("FAIL mid_count cyc=%0d got db=%h r=%h f=%h p=%h irq=%b want db=%h r=%h f=%h p=%h irq=%b",
                         ncyc, o_db_out, o_rise, o_fall, o_pend, o_irq, m_db, m_rise, m_fall, m_pend, |m_pend);
            end
        end
        rst_n = 1'b0;
        #1;
        m_db   = '0;
        m_pend = '0;
        q.delete();
        total++;
        if ({o_db_out, o_rise, o_fall, o_pend, o_irq} !== 17'h0) begin
            bad++;
            $display("FAIL async_reset got db=%h r=%h f=%h p=%h irq=%b want all 0",
                     o_db_out, o_rise, o_fall, o_pend, o_irq);
        end
        for (int k = 0; k < 2; k++) cyc();
        rst_n = 1'b1;
        push(4'b1010, 4'h0);
        for (int k = 0; k < 8; k++) begin
            cyc();
            total++;
            if ({o_db_out, o_rise, o_fall, o_pend, o_irq} !== {m_db, m_rise, m_fall, m_pend, |m_pend}) begin
                bad++;
                $display("FAIL reset_mid cyc=%0d got db=%h r=%h f=%h p=%h irq=%b want db=%h r=%h f=%h p=%h irq=%b",
                         ncyc, o_db_out, o_rise, o_fall, o_pend, o_irq, m_db, m_rise, m_fall, m_pend, |m_pend);
            end
        end
        clr = 4'hF;
        cyc();
        clr = 4'h0;
    endtask

    task automatic test_simultaneous();
        pin = 4'h0;
        push(4'h0, 4'b1010);
        for (int k = 0; k < 8; k++) cyc();
        clr = 4'hF;
        cyc();
        clr = 4'h0;
        pin = 4'b0101;
        push(4'b0101, 4'h0);
        for (int k = 0; k < 10; k++) begin
            clr = (k == 8) ? 4'b0001 : 4'h0;
            cyc();
            total++;
            if ({o_db_out, o_rise, o_fall, o_pend, o_irq} !== {m_db, m_rise, m_fall, m_pend, |m_pend}) begin
                bad++;
                $display("FAIL simultaneous k=%0d got db=%h r=%h f=%h p=%h irq=%b want db=%h r=%h f=%h p=%h irq=%b",
                         k, o_db_out, o_rise, o_fall, o_pend, o_irq, m_db, m_rise, m_fall, m_pend, |m_pend);
            end
        end
        clr = 4'h0;
        total++;
        if (o_pend !== 4'b0100 || o_irq !== 1'b1) begin
            bad++;
            $display("FAIL partial_clear got pend=%h irq=%b want pend=4 irq=1", o_pend, o_irq);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        pin   = 4'h0;
        clr   = 4'h0;
        test_reset();
        test_glitch();
        test_bounce();
        test_clear_race();
        test_reset_mid();
        test_simultaneous();
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got %0d pending events want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
